// File: rtl/recirculador_pkg.sv
// Shared link-state encodings and character constants for the recirculador path.
package recirculador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_ERROR  = 3'd3
  } state_e;

  localparam logic [7:0] K_COMMA    = 8'hBC;
  localparam logic [7:0] K_ERR_CODE = 8'hFF;

endpackage

// File: rtl/recirculador_ctrl_if.sv
// Byte stream in from serial-to-parallel, link status out to the recirculador.
interface recirculador_ctrl_if;
  import recirculador_pkg::*;

  logic [7:0] data_in;
  logic       valid_in;
  logic       active;
  logic [2:0] fsm_state;
  logic [3:0] comma_cnt;
  logic [2:0] err_cnt;
  logic       link_lost;

  modport slave (
    input  data_in, valid_in,
    output active, fsm_state, comma_cnt, err_cnt, link_lost
  );

  modport master (
    output data_in, valid_in,
    input  active, fsm_state, comma_cnt, err_cnt, link_lost
  );

endinterface

// File: rtl/recirculador_ctrl_sat_counter.sv
// Saturating up/down counter with synchronous clear; clear beats inc beats dec.
module sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q != '1) count_d = count_q + ONE;
    end else if (dec) begin
      if (count_q != '0) count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/recirculador_ctrl.sv
// Link-state controller: comma search, active monitoring with error/gap accounting, hold-off.
module recirculador_ctrl
  import recirculador_pkg::*;
#(
  parameter logic [7:0]  COMMA     = K_COMMA,
  parameter logic [7:0]  ERR_CODE  = K_ERR_CODE,
  parameter int unsigned NUM_COMMA = 4,
  parameter int unsigned MAX_ERR   = 3,
  parameter int unsigned MAX_GAP   = 8,
  parameter int unsigned GOOD_RUN  = 16,
  parameter int unsigned HOLD      = 4
) (
  input  logic                clk,
  input  logic                reset,
  recirculador_ctrl_if.slave  bus
);

  localparam logic [3:0] NUM_COMMA_L = 4'(NUM_COMMA);
  localparam logic [3:0] MAX_ERR_L   = 4'(MAX_ERR);
  localparam logic [7:0] MAX_GAP_L   = 8'(MAX_GAP);
  localparam logic [7:0] GOOD_RUN_L  = 8'(GOOD_RUN);
  localparam logic [7:0] HOLD_L      = 8'(HOLD);

  state_e     state_q, state_d;
  logic [3:0] comma_q, comma_d;
  logic       active_q, active_d;
  logic       link_lost_q, link_lost_d;

  logic [7:0] gap_cnt, good_cnt, hold_cnt;
  logic [2:0] err_cnt;
  logic       gap_clr, gap_inc;
  logic       good_clr, good_inc;
  logic       hold_clr, hold_inc;
  logic       err_clr, err_inc, err_dec;

  logic [3:0] comma_nxt;
  logic [3:0] err_nxt;
  logic [7:0] gap_nxt, good_nxt, hold_nxt;
  logic       is_comma, is_err_byte, good_byte, gap_hit, good_done, err_event;

  assign comma_nxt   = comma_q + 4'd1;
  assign err_nxt     = {1'b0, err_cnt} + 4'd1;
  assign gap_nxt     = gap_cnt + 8'd1;
  assign good_nxt    = good_cnt + 8'd1;
  assign hold_nxt    = hold_cnt + 8'd1;
  assign is_comma    = bus.valid_in && (bus.data_in == COMMA);
  assign is_err_byte = bus.valid_in && (bus.data_in == ERR_CODE);
  assign good_byte   = bus.valid_in && (bus.data_in != ERR_CODE);
  assign gap_hit     = !bus.valid_in && (gap_nxt == MAX_GAP_L);
  // A byte is either good or an error, so decay and error never coincide.
  assign good_done   = good_byte && (good_nxt == GOOD_RUN_L);
  assign err_event   = is_err_byte || gap_hit;

  always_comb begin
    state_d     = state_q;
    comma_d     = comma_q;
    active_d    = 1'b0;
    link_lost_d = 1'b0;
    gap_clr     = 1'b1;
    gap_inc     = 1'b0;
    good_clr    = 1'b1;
    good_inc    = 1'b0;
    hold_clr    = 1'b1;
    hold_inc    = 1'b0;
    err_clr     = 1'b0;
    err_inc     = 1'b0;
    err_dec     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_SEARCH;
        comma_d = '0;
        err_clr = 1'b1;
      end
      ST_SEARCH: begin
        err_clr = 1'b1;
        if (is_comma) begin
          if (comma_nxt == NUM_COMMA_L) begin
            state_d  = ST_ACTIVE;
            comma_d  = '0;
            active_d = 1'b1;
          end else begin
            comma_d = comma_nxt;
          end
        end else if (bus.valid_in) begin
          comma_d = '0;
        end
      end
      ST_ACTIVE: begin
        active_d = 1'b1;
        comma_d  = '0;
        gap_clr  = bus.valid_in || gap_hit;
        gap_inc  = !bus.valid_in;
        good_clr = err_event || good_done;
        good_inc = good_byte;
        err_inc  = err_event;
        err_dec  = good_done;
        if (err_event && (err_nxt == MAX_ERR_L)) begin
          state_d     = ST_ERROR;
          active_d    = 1'b0;
          link_lost_d = 1'b1;
        end
      end
      ST_ERROR: begin
        hold_inc = 1'b1;
        hold_clr = (hold_nxt == HOLD_L);
        if (hold_nxt == HOLD_L) begin
          state_d = ST_SEARCH;
          comma_d = '0;
          err_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        comma_d = '0;
        err_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      comma_q     <= '0;
      active_q    <= 1'b0;
      link_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_q     <= comma_d;
      active_q    <= active_d;
      link_lost_q <= link_lost_d;
    end
  end

  sat_counter #(.WIDTH(8)) u_gap (
    .clk(clk), .rst_n(reset), .clr(gap_clr), .inc(gap_inc), .dec(1'b0), .count(gap_cnt)
  );

  sat_counter #(.WIDTH(8)) u_good (
    .clk(clk), .rst_n(reset), .clr(good_clr), .inc(good_inc), .dec(1'b0), .count(good_cnt)
  );

  sat_counter #(.WIDTH(8)) u_hold (
    .clk(clk), .rst_n(reset), .clr(hold_clr), .inc(hold_inc), .dec(1'b0), .count(hold_cnt)
  );

  sat_counter #(.WIDTH(3)) u_err (
    .clk(clk), .rst_n(reset), .clr(err_clr), .inc(err_inc), .dec(err_dec), .count(err_cnt)
  );

  assign bus.active    = active_q;
  assign bus.fsm_state = state_q;
  assign bus.comma_cnt = comma_q;
  assign bus.err_cnt   = err_cnt;
  assign bus.link_lost = link_lost_q;

endmodule

// File: doc/recirculador_ctrl.md
Name: recirculador_ctrl

Overview:
Link-state controller that generates the `active` signal consumed by the recirculador. It monitors the byte stream from the serial-to-parallel block and declares the link active after a run of consecutive comma characters. It drops `active` when errors or valid-gaps accumulate. After an error hold-off it returns to comma search.

Parameters:
COMMA, 8'hBC, comma character value.
ERR_CODE, 8'hFF, byte value counted as a line error while active.
NUM_COMMA, 4, consecutive valid commas required to go active (range 1..15).
MAX_ERR, 3, error count that forces ERROR (range 1..7).
MAX_GAP, 8, consecutive idle (valid_in=0) cycles tolerated while active (range 1..255).
GOOD_RUN, 16, consecutive good valid bytes that decrement err_cnt by 1 (range 1..255).
HOLD, 4, cycles spent in ERROR before returning to SEARCH (range 1..255).

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset (reset==0 clears everything immediately).
data_in  input  8  byte from serial-to-parallel.
valid_in  input  1  data_in qualifier.
active  output  1  registered; drives recirculador `active`.
fsm_state  output  3  registered state code: IDLE=0, SEARCH=1, ACTIVE=2, ERROR=3.
comma_cnt  output  4  registered count of consecutive valid commas in SEARCH.
err_cnt  output  3  registered error count in ACTIVE.
link_lost  output  1  registered one-cycle pulse on ACTIVE->ERROR.

Behaviour:
- Reset (reset==0, asynchronous):
  - fsm_state=IDLE, active=0, comma_cnt=0, err_cnt=0, link_lost=0.
  - Internal gap, good-run and hold counters=0.
- IDLE: unconditionally go to SEARCH on the first posedge after reset release. Inputs are ignored in that cycle.
- SEARCH:
  - valid_in=1 and data_in==COMMA: comma_cnt+1.
  - valid_in=1 and data_in!=COMMA: comma_cnt=0.
  - valid_in=0: comma_cnt holds.
  - When the current valid comma makes the count reach NUM_COMMA, on that same edge: fsm_state=ACTIVE, active=1, comma_cnt=0, err_cnt=0, gap=0, good-run=0.
  - Latency: active is high the cycle after the NUM_COMMA-th valid comma is sampled.
- ACTIVE, evaluated each cycle; active stays 1:
  - Error event:
    - valid_in=1 and data_in==ERR_CODE; or
    - gap counter reaches MAX_GAP. The gap counter increments on valid_in=0 and clears on valid_in=1. Reaching MAX_GAP counts one error and clears the gap counter.
  - Error handling: err_cnt+1 (saturating at 7) and good-run cleared.
  - Good byte (valid_in=1, data_in!=ERR_CODE; commas count as good): good-run+1. When good-run reaches GOOD_RUN, clear good-run and decrement err_cnt if nonzero.
  - Simultaneous good-run terminal and error in the same cycle is impossible (exclusive by definition). An error always wins over decay.
  - When err_cnt+1 would reach MAX_ERR, on that edge: fsm_state=ERROR, active=0, link_lost=1 for exactly one cycle, hold counter=0.
- ERROR:
  - active=0; inputs ignored; hold counter increments.
  - After HOLD cycles in ERROR, go to SEARCH with comma_cnt=0 and err_cnt=0.
- link_lost is 0 in every cycle except the one following the ACTIVE->ERROR edge.
- Reset mid-operation: from any state, reset==0 forces all outputs low/IDLE asynchronously, without waiting for clk.
- All counters use widths sized to their parameter range. Comparisons use ==, never overflow wrap.
- fsm_state encodings 4..7 are unreachable; they recover to IDLE on the next edge.

Decomposition:
- Shared package/header recirculador_pkg:
  - state encodings IDLE/SEARCH/ACTIVE/ERROR (3 bits);
  - COMMA and ERR_CODE constants, reusable by the serial-to-parallel and test generators.
- One natural sub-module: sat_counter (parameterised width, inc/clr/dec/saturate). It is instantiated for the gap, good-run, hold and error counters. The FSM remains in recirculador_ctrl.

Test Plan:
1. Reset held low 3 cycles, then released, then 4 valid 0xBC -> fsm_state IDLE->SEARCH; comma_cnt 1,2,3; active=1 and fsm_state=2 on the cycle after the 4th comma.
2. SEARCH with 0xBC,0xBC,0x12,0xBC,0xBC,0xBC,0xBC (all valid) -> comma_cnt resets to 0 at 0x12; active rises only after the final comma.
3. ACTIVE, then 3 valid 0xFF bytes separated by 2 good bytes -> err_cnt 1,2, then ERROR; active=0; link_lost high exactly one cycle. After 4 cycles fsm_state=SEARCH with err_cnt=0.
4. ACTIVE with valid_in=0 for 8 cycles -> err_cnt=1 and gap cleared. Then 16 valid 0x55 bytes -> err_cnt back to 0.
5. ACTIVE, then reset pulled low between clock edges -> active=0 and fsm_state=0 before the next posedge; no link_lost pulse.
6. ERROR state fed 0xBC stream -> comma_cnt stays 0 until SEARCH re-entered. Counting then starts fresh; active after 4 further commas.
